// File: rtl/cla_pkg.sv
// Shared constants and state encoding for the streaming carry-lookahead adder.
package cla_pkg;

  localparam int W_DEFAULT = 4;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

endpackage

// File: rtl/cla_stream_adder_if.sv
// Stream interface between pgu and the adder (p/g beats in, result beats out).
interface cla_stream_adder_if import cla_pkg::*; #(parameter int W = W_DEFAULT);

  logic         cin;
  logic         in_valid;
  logic         in_ready;
  logic         in_first;
  logic         in_last;
  logic [W-1:0] p;
  logic [W-1:0] g;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_sum;
  logic         out_last;
  logic         out_cout;
  logic         out_ovf;
  logic         out_bp;
  logic         out_bg;
  logic         proto_err;

  modport slave (
    input  cin, in_valid, in_first, in_last, p, g, out_ready,
    output in_ready, out_valid, out_sum, out_last, out_cout, out_ovf,
           out_bp, out_bg, proto_err
  );

  modport master (
    output cin, in_valid, in_first, in_last, p, g, out_ready,
    input  in_ready, out_valid, out_sum, out_last, out_cout, out_ovf,
           out_bp, out_bg, proto_err
  );

endinterface

// File: rtl/cla_lookahead.sv
// Combinational carry lookahead for one W-bit group; every carry is a flat
// sum-of-products of g, p and c0, so no carry ripples through another.
module cla_lookahead #(parameter int W = 4) (
  input  logic [W-1:0] p,
  input  logic [W-1:0] g,
  input  logic         c0,
  output logic [W:0]   c,
  output logic [W-1:0] sum,
  output logic         bp,
  output logic         bg
);

  // c[idx] = g[idx-1] | p[idx-1]g[idx-2] | ... | p[idx-1..0]c0
  function automatic logic la_carry(input logic [W-1:0] p_v, input logic [W-1:0] g_v,
                                    input logic c0_v, input int idx);
    logic acc;
    logic term;
    acc = c0_v;
    for (int j = 0; j < idx; j++) acc = acc & p_v[j];
    for (int k = 0; k < idx; k++) begin
      term = g_v[k];
      for (int j = k + 1; j < idx; j++) term = term & p_v[j];
      acc = acc | term;
    end
    return acc;
  endfunction

  for (genvar i = 0; i <= W; i++) begin : g_carry
    assign c[i] = la_carry(p, g, c0, i);
  end

  assign sum = p ^ c[W-1:0];
  assign bp  = &p;
  assign bg  = la_carry(p, g, 1'b0, W);

endmodule

// File: rtl/cla_stream_adder.sv
// Multi-beat adder: lookahead within a beat, registered carry across beats,
// one-stage output register with valid/ready handshake.
module cla_stream_adder import cla_pkg::*; #(parameter int W = W_DEFAULT) (
  input  logic              clk,
  input  logic              rst_n,
  cla_stream_adder_if.slave bus
);

  state_t       state_r;
  state_t       state_nxt_s;
  logic         carry_r;
  logic         start_s;
  logic         err_s;
  logic         xfer_s;
  logic         ready_s;
  logic         c0_s;
  logic [W:0]   c_s;
  logic [W-1:0] sum_s;
  logic         bp_s;
  logic         bg_s;
  logic         carry_unused_s;

  logic         out_valid_r;
  logic [W-1:0] out_sum_r;
  logic         out_last_r;
  logic         out_cout_r;
  logic         out_ovf_r;
  logic         out_bp_r;
  logic         out_bg_r;

  // Ready is forced low while reset is held so every output reads 0 in reset.
  assign ready_s = rst_n & (~out_valid_r | bus.out_ready);
  assign xfer_s  = bus.in_valid & ready_s;

  // Operand start and framing-error decode; an unframed IDLE beat still starts an operand.
  always_comb begin
    start_s = bus.in_first | (state_r == IDLE);
    err_s   = bus.in_first ? (state_r == BUSY) : (state_r == IDLE);
    c0_s    = start_s ? bus.cin : carry_r;
  end

  cla_lookahead #(.W(W)) u_la (
    .p   (bus.p),
    .g   (bus.g),
    .c0  (c0_s),
    .c   (c_s),
    .sum (sum_s),
    .bp  (bp_s),
    .bg  (bg_s)
  );

  // Intermediate carries are consumed inside the lookahead only.
  assign carry_unused_s = &{1'b0, c_s[W-2:0]};

  // Next-state logic; the state only moves on a transfer.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE, BUSY: begin
        if (xfer_s) begin
          state_nxt_s = bus.in_last ? IDLE : BUSY;
        end else begin
          state_nxt_s = state_r;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // State and inter-beat carry registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      carry_r <= 1'b0;
    end else if (xfer_s) begin
      state_r <= state_nxt_s;
      carry_r <= c_s[W];
    end else begin
      state_r <= state_r;
      carry_r <= carry_r;
    end
  end

  // Output register: load on transfer, drop valid when taken, otherwise hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_r <= 1'b0;
      out_sum_r   <= {W{1'b0}};
      out_last_r  <= 1'b0;
      out_cout_r  <= 1'b0;
      out_ovf_r   <= 1'b0;
      out_bp_r    <= 1'b0;
      out_bg_r    <= 1'b0;
    end else if (xfer_s) begin
      out_valid_r <= 1'b1;
      out_sum_r   <= sum_s;
      out_last_r  <= bus.in_last;
      out_cout_r  <= c_s[W];
      out_ovf_r   <= bus.in_last ? (c_s[W] ^ c_s[W-1]) : 1'b0;
      out_bp_r    <= bp_s;
      out_bg_r    <= bg_s;
    end else if (bus.out_ready) begin
      out_valid_r <= 1'b0;
    end else begin
      out_valid_r <= out_valid_r;
    end
  end

  assign bus.in_ready  = ready_s;
  assign bus.proto_err = xfer_s & err_s;
  assign bus.out_valid = out_valid_r;
  assign bus.out_sum   = out_sum_r;
  assign bus.out_last  = out_last_r;
  assign bus.out_cout  = out_cout_r;
  assign bus.out_ovf   = out_ovf_r;
  assign bus.out_bp    = out_bp_r;
  assign bus.out_bg    = out_bg_r;

endmodule

// File: tb/tb_cla_stream_adder.sv
// Bench for cla_stream_adder: directed framing/handshake scenarios plus random
// 32-bit operands checked against plain integer addition.
module tb_cla_stream_adder;
  import cla_pkg::*;

  localparam int W = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  cla_stream_adder_if #(.W(W)) bus ();
  cla_stream_adder #(.W(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int   total = 0;
  int   bad = 0;
  bit   m_busy = 1'b0;
  bit   m_carry = 1'b0;
  logic seen_err;

  typedef struct packed {
    logic [3:0] sum;
    logic       cout;
    logic       ovf;
    logic       bp;
    logic       bg;
    logic       err;
  } exp_t;

  // Reference: rebuild operands a=p|g, b=g and add them as integers.
  task automatic model_beat(input logic [3:0] p, input logic [3:0] g, input logic first,
                            input logic last, input logic ci_in, output exp_t e);
    int a, b, ci, tot;
    bit start;
    a = int'(p | g);
    b = int'(g);
    start = first || !m_busy;
    e.err = (first && m_busy) || (!first && !m_busy);
    ci = start ? int'(ci_in) : int'(m_carry);
    tot = a + b + ci;
    e.sum = 4'(tot);
    e.cout = (tot >= 16);
    e.ovf = last && ((tot >= 16) != (((a % 8) + (b % 8) + ci) >= 8));
    e.bp = (p == 4'hF);
    e.bg = ((a + b) >= 16);
    m_carry = e.cout;
    m_busy = !last;
  endtask

  function automatic logic [7:0] vexp(input exp_t e);
    return {e.sum, e.cout, e.ovf, e.bp, e.bg};
  endfunction

  function automatic logic [7:0] vobs();
    return {bus.out_sum, bus.out_cout, bus.out_ovf, bus.out_bp, bus.out_bg};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One beat with out_ready=1; returns #1 after the accepting edge.
  task automatic drive(input logic [3:0] p, input logic [3:0] g, input logic first, input logic last);
    bus.p = p; bus.g = g; bus.in_first = first; bus.in_last = last; bus.in_valid = 1'b1;
    @(negedge clk);
    seen_err = bus.proto_err;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0; bus.in_first = 1'b0; bus.in_last = 1'b0;
  endtask

  task automatic test_reset();
    logic [12:0] o;
    #1 rst_n = 1'b0;
    #2;
    o = {bus.in_ready, bus.out_valid, bus.out_sum, bus.out_last, bus.out_cout,
         bus.out_ovf, bus.out_bp, bus.out_bg, bus.proto_err};
    total++;
    if (o !== 13'd0) begin bad++; $display("FAIL reset_outputs got=%h want=0", o); end
    tick();
    rst_n = 1'b1;
    tick();
    total++;
    if ({bus.in_ready, bus.out_valid} !== 2'b10) begin
      bad++; $display("FAIL post_reset got=%b want=10", {bus.in_ready, bus.out_valid});
    end
  endtask

  task automatic test_carry_chain();
    logic [3:0] pv [4] = '{4'hE, 4'hF, 4'hF, 4'hF};
    logic [3:0] gv [4] = '{4'h1, 4'h0, 4'h0, 4'h0};
    exp_t e;
    bus.cin = 1'b0;
    for (int i = 0; i < 4; i++) begin
      model_beat(pv[i], gv[i], i == 0, i == 3, 1'b0, e);
      drive(pv[i], gv[i], i == 0, i == 3);
      total++;
      if ({seen_err, bus.out_valid, bus.out_last, vobs()} !== {1'b0, 1'b1, 1'(i == 3), vexp(e)}) begin
        bad++;
        $display("FAIL chain_beat%0d got=%h want=%h", i, {seen_err, bus.out_valid, bus.out_last, vobs()},
                 {1'b0, 1'b1, 1'(i == 3), vexp(e)});
      end
    end
    tick();
  endtask

  task automatic test_single_beat();
    exp_t e;
    bus.cin = 1'b0;
    model_beat(4'h6, 4'h1, 1'b1, 1'b1, 1'b0, e);
    drive(4'h6, 4'h1, 1'b1, 1'b1);
    total++;
    if ({bus.out_valid, bus.out_last, vobs()} !== {2'b11, 4'h8, 4'b0100} ||
        vexp(e) !== {4'h8, 4'b0100}) begin
      bad++; $display("FAIL single_beat got=%h want=%h", {bus.out_valid, bus.out_last, vobs()}, {2'b11, vexp(e)});
    end
    tick();
    total++;
    if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL single_no_dup got=%b want=0", bus.out_valid); end
  endtask

  task automatic test_back_pressure();
    exp_t ea, eb;
    bus.cin = 1'b0;
    model_beat(4'hF, 4'h0, 1'b1, 1'b0, 1'b0, ea);
    drive(4'hF, 4'h0, 1'b1, 1'b0);
    bus.out_ready = 1'b0;
    bus.p = 4'h0; bus.g = 4'hF; bus.in_first = 1'b0; bus.in_last = 1'b1; bus.in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if ({bus.in_ready, bus.out_valid, vobs()} !== {2'b01, vexp(ea)}) begin
        bad++; $display("FAIL bp_hold%0d got=%h want=%h", i, {bus.in_ready, bus.out_valid, vobs()}, {2'b01, vexp(ea)});
      end
      tick();
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    total++;
    if ({bus.in_ready, bus.out_valid, vobs()} !== {2'b11, vexp(ea)}) begin
      bad++; $display("FAIL bp_release got=%h want=%h", {bus.in_ready, bus.out_valid, vobs()}, {2'b11, vexp(ea)});
    end
    model_beat(4'h0, 4'hF, 1'b0, 1'b1, 1'b0, eb);
    tick();
    bus.in_valid = 1'b0; bus.in_last = 1'b0;
    total++;
    if ({bus.out_valid, bus.out_last, vobs()} !== {2'b11, vexp(eb)}) begin
      bad++; $display("FAIL bp_second got=%h want=%h", {bus.out_valid, bus.out_last, vobs()}, {2'b11, vexp(eb)});
    end
    tick();
    total++;
    if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL bp_no_dup got=%b want=0", bus.out_valid); end
  endtask

  task automatic test_first_in_busy();
    exp_t e;
    bus.cin = 1'b0;
    model_beat(4'hF, 4'h0, 1'b1, 1'b0, 1'b0, e);
    drive(4'hF, 4'h0, 1'b1, 1'b0);
    bus.cin = 1'b1;
    model_beat(4'h0, 4'h0, 1'b1, 1'b0, 1'b1, e);
    drive(4'h0, 4'h0, 1'b1, 1'b0);
    total++;
    if ({seen_err, bus.out_sum} !== {1'b1, 4'h1} || {e.err, e.sum} !== {1'b1, 4'h1}) begin
      bad++; $display("FAIL first_in_busy got=%h want=%h", {seen_err, bus.out_sum}, {e.err, e.sum});
    end
    @(negedge clk);
    total++;
    if (bus.proto_err !== 1'b0) begin bad++; $display("FAIL err_one_cycle got=%b want=0", bus.proto_err); end
    tick();
    bus.cin = 1'b0;
    model_beat(4'h0, 4'h0, 1'b0, 1'b1, 1'b0, e);
    drive(4'h0, 4'h0, 1'b0, 1'b1);
    total++;
    if ({seen_err, vobs()} !== {e.err, vexp(e)}) begin
      bad++; $display("FAIL busy_tail got=%h want=%h", {seen_err, vobs()}, {e.err, vexp(e)});
    end
    tick();
  endtask

  task automatic test_reset_mid_operand();
    exp_t e;
    bus.cin = 1'b0;
    model_beat(4'hF, 4'h0, 1'b1, 1'b0, 1'b0, e);
    drive(4'hF, 4'h0, 1'b1, 1'b0);
    model_beat(4'h0, 4'hF, 1'b0, 1'b0, 1'b0, e);
    drive(4'h0, 4'hF, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    total++;
    if ({bus.out_valid, bus.out_sum} !== 5'd0) begin
      bad++; $display("FAIL mid_reset got=%h want=0", {bus.out_valid, bus.out_sum});
    end
    tick();
    rst_n = 1'b1;
    m_busy = 1'b0; m_carry = 1'b0;
    bus.cin = 1'b1;
    model_beat(4'h0, 4'h0, 1'b0, 1'b0, 1'b1, e);
    drive(4'h0, 4'h0, 1'b0, 1'b0);
    total++;
    if ({seen_err, bus.out_valid, vobs()} !== {e.err, 1'b1, vexp(e)} || e.err !== 1'b1) begin
      bad++; $display("FAIL after_reset got=%h want=%h", {seen_err, bus.out_valid, vobs()}, {e.err, 1'b1, vexp(e)});
    end
    bus.cin = 1'b0;
    model_beat(4'h0, 4'h0, 1'b0, 1'b1, 1'b0, e);
    drive(4'h0, 4'h0, 1'b0, 1'b1);
    tick();
  endtask

  task automatic test_random();
    logic [31:0] av [8];
    logic [31:0] bv [8];
    logic        cv [8];
    logic [31:0] res [8];
    logic        couts [8];
    logic [63:0] lbits;
    logic [32:0] want;
    int drv_done, col_done, errs;
    errs = 0; lbits = 64'd0;
    for (int o = 0; o < 8; o++) begin
      av[o] = $urandom; bv[o] = $urandom; cv[o] = 1'($urandom_range(0, 1));
      res[o] = 32'd0; couts[o] = 1'b0;
    end
    fork
      begin
        int bi = 0;
        int guard = 0;
        while (bi < 64 && guard < 3000) begin
          logic [3:0] an, bn;
          guard++;
          an = av[bi / 8][4 * (bi % 8) +: 4];
          bn = bv[bi / 8][4 * (bi % 8) +: 4];
          bus.p = an ^ bn; bus.g = an & bn; bus.cin = cv[bi / 8];
          bus.in_first = (bi % 8 == 0); bus.in_last = (bi % 8 == 7);
          bus.in_valid = ($urandom_range(0, 3) != 0);
          @(negedge clk);
          if (bus.in_valid && bus.in_ready) begin
            if (bus.proto_err) errs++;
            bi++;
          end
          tick();
        end
        bus.in_valid = 1'b0;
        drv_done = bi;
      end
      begin
        int ob = 0;
        int guard = 0;
        while (ob < 64 && guard < 3000) begin
          guard++;
          bus.out_ready = ($urandom_range(0, 2) != 0);
          @(negedge clk);
          if (bus.out_valid && bus.out_ready) begin
            res[ob / 8][4 * (ob % 8) +: 4] = bus.out_sum;
            lbits[ob] = bus.out_last;
            if (ob % 8 == 7) couts[ob / 8] = bus.out_cout;
            ob++;
          end
          tick();
        end
        col_done = ob;
      end
    join
    bus.out_ready = 1'b1;
    total++;
    if (drv_done != 64 || col_done != 64) begin
      bad++; $display("FAIL rand_timeout got=%0d/%0d want=64/64", drv_done, col_done);
    end
    total++;
    if (errs != 0 || lbits !== 64'h8080808080808080) begin
      bad++; $display("FAIL rand_framing got=%0d,%h want=0,8080808080808080", errs, lbits);
    end
    for (int o = 0; o < 8; o++) begin
      want = {1'b0, av[o]} + {1'b0, bv[o]} + {32'd0, cv[o]};
      total++;
      if ({couts[o], res[o]} !== want) begin
        bad++; $display("FAIL rand_op%0d got=%h want=%h", o, {couts[o], res[o]}, want);
      end
    end
  endtask

  initial begin
    bus.cin = 1'b0; bus.in_valid = 1'b0; bus.in_first = 1'b0; bus.in_last = 1'b0;
    bus.p = 4'h0; bus.g = 4'h0; bus.out_ready = 1'b1;
    test_reset();
    test_carry_chain();
    test_single_beat();
    test_back_pressure();
    test_first_in_busy();
    test_reset_mid_operand();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
